// File: rtl/tick_rst_gen.sv
// Clock-enable and reset generator: stretched reset_out/ready plus NUM_CH divided tick streams.
// Define TICK_RST_GEN_TOGGLE_EN to add the per-channel 50%-duty ch_clk outputs.
module tick_rst_gen #(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 16,
    parameter int RST_HOLD = 8
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*DIV_W-1:0] ch_div,
    input  logic                    resync,
    output logic                    reset_out,
    output logic                    ready,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH*8-1:0]     tick_cnt
`ifdef TICK_RST_GEN_TOGGLE_EN
    ,
    output logic [NUM_CH-1:0]       ch_clk
`endif
);

    localparam int HOLD_W = $clog2(RST_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt;

    // reset_out falls on the RST_HOLD-th edge seen with reset low; the counter then parks
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            hold_cnt  <= '0;
            reset_out <= 1'b1;
            ready     <= 1'b0;
        end else if (reset_out) begin
            if (hold_cnt == HOLD_LAST) begin
                reset_out <= 1'b0;
                ready     <= 1'b1;
            end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] ph;
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] div_in;
        logic             en_q;
        logic             tick_q;
        logic [7:0]       cnt_q;
        logic             wrap;

        assign div_in = ch_div[i*DIV_W +: DIV_W];
        assign wrap   = ch_en[i] && en_q && (ph == div_q);
        assign tick[i] = tick_q;
        assign tick_cnt[i*8 +: 8] = cnt_q;

        // The first enabled edge only latches the divide, so the first tick lands D+1 edges later
        always_ff @(posedge CLOCK_50 or posedge reset) begin
            if (reset) begin
                ph     <= '0;
                div_q  <= '0;
                en_q   <= 1'b0;
                tick_q <= 1'b0;
                cnt_q  <= '0;
            end else if (reset_out) begin
                ph     <= '0;
                div_q  <= '0;
                en_q   <= 1'b0;
                tick_q <= 1'b0;
                cnt_q  <= '0;
            end else if (resync) begin
                ph     <= '0;
                div_q  <= div_in;
                en_q   <= ch_en[i];
                tick_q <= 1'b0;
            end else if (!ch_en[i]) begin
                ph     <= '0;
                en_q   <= 1'b0;
                tick_q <= 1'b0;
            end else if (!en_q) begin
                ph     <= '0;
                div_q  <= div_in;
                en_q   <= 1'b1;
                tick_q <= 1'b0;
            end else if (wrap) begin
                ph     <= '0;
                div_q  <= div_in;
                tick_q <= 1'b1;
                cnt_q  <= cnt_q + 8'd1;
            end else begin
                ph     <= ph + DIV_W'(1);
                tick_q <= 1'b0;
            end
        end

`ifdef TICK_RST_GEN_TOGGLE_EN
        logic clk_q;

        assign ch_clk[i] = clk_q;

        always_ff @(posedge CLOCK_50 or posedge reset) begin
            if (reset) begin
                clk_q <= 1'b0;
            end else if (reset_out || resync) begin
                clk_q <= 1'b0;
            end else if (wrap) begin
                clk_q <= ~clk_q;
            end
        end
`else
        // No toggle flops in this build.
`endif
    end

endmodule

// File: tb/tb_tick_rst_gen.sv
// Scoreboard bench for tick_rst_gen: an event-schedule model predicts each edge's outputs,
// a monitor pops and compares them one edge later.
module tb_tick_rst_gen;

    localparam int NUM_CH   = 4;
    localparam int DIV_W    = 16;
    localparam int RST_HOLD = 8;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH*DIV_W-1:0] ch_div;
    logic                    resync;
    logic                    reset_out;
    logic                    ready;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH*8-1:0]     tick_cnt;
`ifdef TICK_RST_GEN_TOGGLE_EN
    logic [NUM_CH-1:0]       ch_clk;
`endif

    tick_rst_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .RST_HOLD(RST_HOLD)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .ch_en    (ch_en),
        .ch_div   (ch_div),
        .resync   (resync),
        .reset_out(reset_out),
        .ready    (ready),
        .tick     (tick),
        .tick_cnt (tick_cnt)
`ifdef TICK_RST_GEN_TOGGLE_EN
        ,
        .ch_clk   (ch_clk)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                ro;
        logic                rdy;
        logic [NUM_CH-1:0]   tk;
        logic [NUM_CH*8-1:0] cnt;
        logic [NUM_CH-1:0]   cc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Stimulus state
    logic [NUM_CH-1:0] en_v;
    logic [DIV_W-1:0]  div_v [NUM_CH];
    logic              rs_v;
    logic              rst_v;

    // Model state: ticks are scheduled as absolute edge numbers
    int edge_k;
    int rst_low;
    bit armed  [NUM_CH];
    int next_t [NUM_CH];
    int cnt_m  [NUM_CH];
    bit clk_m  [NUM_CH];

    function automatic void check_output(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        rst_low = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            armed[i] = 1'b0;
            cnt_m[i] = 0;
            clk_m[i] = 1'b0;
        end
    endfunction

    function automatic void model_step();
        exp_t e;
        bit   run;
        edge_k++;
        e.tk = '0;
        if (rst_v) begin
            model_reset();
        end else begin
            run = (rst_low >= RST_HOLD);
            if (rst_low < RST_HOLD) rst_low++;
            if (run) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (rs_v) begin
                        armed[i] = en_v[i];
                        next_t[i] = edge_k + int'(div_v[i]) + 1;
                        clk_m[i] = 1'b0;
                    end else if (!en_v[i]) begin
                        armed[i] = 1'b0;
                    end else if (!armed[i]) begin
                        armed[i] = 1'b1;
                        next_t[i] = edge_k + int'(div_v[i]) + 1;
                    end else if (edge_k == next_t[i]) begin
                        e.tk[i] = 1'b1;
                        cnt_m[i] = (cnt_m[i] + 1) % 256;
                        clk_m[i] = ~clk_m[i];
                        next_t[i] = edge_k + int'(div_v[i]) + 1;
                    end
                end
            end
        end
        e.ro  = (rst_low < RST_HOLD);
        e.rdy = ~e.ro;
        for (int i = 0; i < NUM_CH; i++) begin
            e.cnt[i*8 +: 8] = 8'(cnt_m[i]);
            e.cc[i]         = clk_m[i];
        end
        sb.push_back(e);
    endfunction

    task automatic apply_stimulus();
        reset  = rst_v;
        resync = rs_v;
        ch_en  = en_v;
        for (int i = 0; i < NUM_CH; i++) ch_div[i*DIV_W +: DIV_W] = div_v[i];
        model_step();
        @(negedge clk);
    endtask

    task automatic run_cycles(int n);
        for (int c = 0; c < n; c++) apply_stimulus();
    endtask

    task automatic run_random(int n);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 19) == 0) en_v[i] = ~en_v[i];
                if ($urandom_range(0, 14) == 0) div_v[i] = DIV_W'($urandom_range(0, 12));
            end
            rs_v = ($urandom_range(0, 24) == 0);
            apply_stimulus();
        end
        rs_v = 1'b0;
    endtask

    // Monitor: every edge produces one registered output set to compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                check_output("scoreboard_empty", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check_output("reset_out", 64'(reset_out), 64'(e.ro));
                check_output("ready",     64'(ready),     64'(e.rdy));
                check_output("tick",      64'(tick),      64'(e.tk));
                check_output("tick_cnt",  64'(tick_cnt),  64'(e.cnt));
`ifdef TICK_RST_GEN_TOGGLE_EN
                check_output("ch_clk",    64'(ch_clk),    64'(e.cc));
`endif
            end
        end
    end

    initial begin
        edge_k = 0;
        en_v   = '0;
        rs_v   = 1'b0;
        rst_v  = 1'b1;
        for (int i = 0; i < NUM_CH; i++) div_v[i] = DIV_W'(3);
        model_reset();

        // Reset pulse, then the stretched release with no channels running
        run_cycles(3);
        rst_v = 1'b0;
        run_cycles(12);

        // ch0 divide by 5
        div_v[0] = DIV_W'(4);
        en_v[0]  = 1'b1;
        run_cycles(20);

        // ch1 ticking every edge long enough to wrap its counter
        div_v[1] = DIV_W'(0);
        en_v[1]  = 1'b1;
        run_cycles(270);
        en_v[1]  = 1'b0;

        // ch2 divide change mid-period
        div_v[2] = DIV_W'(9);
        en_v[2]  = 1'b1;
        run_cycles(15);
        div_v[2] = DIV_W'(2);
        run_cycles(20);
        en_v[2]  = 1'b0;

        // Resync of ch0 (div 4) and ch3 (div 1)
        div_v[0] = DIV_W'(4);
        div_v[3] = DIV_W'(1);
        en_v[3]  = 1'b1;
        run_cycles(7);
        rs_v = 1'b1;
        run_cycles(1);
        rs_v = 1'b0;
        run_cycles(12);

        // ch_clk period check with divide 2, then random traffic
        div_v[0] = DIV_W'(2);
        run_cycles(14);
        run_random(1500);

        // Asynchronous reset mid-run
        en_v[0]  = 1'b1;
        div_v[0] = DIV_W'(1);
        run_cycles(9);
        rst_v = 1'b1;
        reset = 1'b1;
        #1;
        model_reset();
        check_output("async_reset_out", 64'(reset_out), 64'd1);
        check_output("async_ready",     64'(ready),     64'd0);
        check_output("async_tick",      64'(tick),      64'd0);
        check_output("async_tick_cnt",  64'(tick_cnt),  64'd0);
`ifdef TICK_RST_GEN_TOGGLE_EN
        check_output("async_ch_clk",    64'(ch_clk),    64'd0);
`endif
        run_cycles(2);
        rst_v = 1'b0;
        run_random(200);

        check_output("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
